// File: rtl/vending_pkg.sv
// Shared types for the vending controller: FSM state encoding and coin decoding.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   localparam logic [1:0] COIN_5   = 2'd0;
   localparam logic [1:0] COIN_10  = 2'd1;
   localparam logic [1:0] COIN_20  = 2'd2;
   localparam logic [1:0] COIN_BAD = 2'd3;

   localparam int COIN_VAL_W = 5;

   // Face value of a coin code; the invalid code is worth nothing.
   function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_5:  return COIN_VAL_W'(5);
         COIN_10: return COIN_VAL_W'(10);
         COIN_20: return COIN_VAL_W'(20);
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/vend_price_lut.sv
// Combinational price table: maps a product index to (index+1)*PRICE_STEP and
// flags indices beyond NUM_PRODUCTS. All prices are fixed at elaboration.
module vend_price_lut #(
   parameter int NUM_PRODUCTS = 4,
   parameter int PRICE_STEP   = 5,
   parameter int CREDIT_W     = 6,
   localparam int SEL_W       = $clog2(NUM_PRODUCTS),
   localparam int PRICE_W     = CREDIT_W + 1
) (
   input  logic [SEL_W-1:0]   sel,
   output logic [PRICE_W-1:0] price,
   output logic               in_range
);

   localparam int TAB_N     = 2 ** SEL_W;
   localparam int PRICE_MAX = 2 ** PRICE_W - 1;

   logic [PRICE_W-1:0] price_tab [TAB_N];

   // A price too large for the datapath saturates; it still exceeds any credit.
   for (genvar k = 0; k < TAB_N; k++) begin : g_price
      localparam int P = (k + 1) * PRICE_STEP;
      assign price_tab[k] = (P > PRICE_MAX) ? PRICE_W'(PRICE_MAX) : PRICE_W'(P);
   end

   assign price    = price_tab[sel];
   assign in_range = (32'(sel) < NUM_PRODUCTS);

endmodule

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit, selection, dispense pulse and
// change handshake. Define VEND_STATS_EN to add vend/refund statistics counters.
module vending_fsm_param
   import vending_pkg::*;
#(
   parameter int NUM_PRODUCTS = 4,
   parameter int PRICE_STEP   = 5,
   parameter int CREDIT_W     = 6,
   parameter int MAX_CREDIT   = 40,
   localparam int SEL_W       = $clog2(NUM_PRODUCTS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin_code,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   input  logic                cancel,
   input  logic                change_ack,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                sel_short,
   output logic                dispense,
   output logic [SEL_W-1:0]    dispense_id,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt
`ifdef VEND_STATS_EN
   ,
   output logic [15:0]         vend_count,
   output logic [15:0]         refund_count
`endif
);

   localparam int SUM_W = CREDIT_W + 1;

   if (NUM_PRODUCTS < 2 || NUM_PRODUCTS > 16) begin : g_bad_num_products
      $error("vending_fsm_param: NUM_PRODUCTS must be within 2..16");
   end
   if (MAX_CREDIT < 1 || MAX_CREDIT >= 2 ** CREDIT_W) begin : g_bad_max_credit
      $error("vending_fsm_param: MAX_CREDIT must fit in CREDIT_W bits");
   end

   state_t           state;
   logic [SUM_W-1:0] price;
   logic             sel_in_range;
   logic [SUM_W-1:0] coin_val;
   logic [SUM_W-1:0] coin_sum;
   logic             coin_ok;
   logic             sel_ok;

   vend_price_lut #(
      .NUM_PRODUCTS (NUM_PRODUCTS),
      .PRICE_STEP   (PRICE_STEP),
      .CREDIT_W     (CREDIT_W)
   ) u_price_lut (
      .sel      (sel),
      .price    (price),
      .in_range (sel_in_range)
   );

   // NOTE: every always_comb output is assigned on every path (here unconditionally),
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      coin_val = SUM_W'(coin_value(coin_code));
      coin_sum = {1'b0, credit} + coin_val;
      coin_ok  = (coin_code != COIN_BAD) && (coin_sum <= SUM_W'(MAX_CREDIT));
      sel_ok   = sel_in_range && ({1'b0, credit} >= price);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         credit       <= '0;
         coin_reject  <= 1'b0;
         sel_short    <= 1'b0;
         dispense     <= 1'b0;
         dispense_id  <= '0;
         change_valid <= 1'b0;
         change_amt   <= '0;
      end else begin
         coin_reject <= 1'b0;
         sel_short   <= 1'b0;
         dispense    <= 1'b0;
         dispense_id <= '0;

         case (state)
            IDLE: begin
               if (sel_valid) sel_short <= 1'b1;
               if (coin_valid) begin
                  if (coin_ok) begin
                     credit <= coin_sum[CREDIT_W-1:0];
                     state  <= CREDIT;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
            end

            // Strobe priority here is cancel > sel_valid > coin_valid.
            CREDIT: begin
               if (cancel) begin
                  coin_reject  <= coin_valid;
                  change_valid <= 1'b1;
                  change_amt   <= credit;
                  state        <= CHANGE;
               end else if (sel_valid) begin
                  coin_reject <= coin_valid;
                  if (sel_ok) begin
                     dispense    <= 1'b1;
                     dispense_id <= sel;
                     credit      <= credit - price[CREDIT_W-1:0];
                     state       <= VEND;
                  end else begin
                     sel_short <= 1'b1;
                  end
               end else if (coin_valid) begin
                  if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
                  else         coin_reject <= 1'b1;
               end
            end

            VEND: begin
               coin_reject <= coin_valid;
               if (credit != '0) begin
                  change_valid <= 1'b1;
                  change_amt   <= credit;
                  state        <= CHANGE;
               end else begin
                  state <= IDLE;
               end
            end

            CHANGE: begin
               coin_reject <= coin_valid;
               if (change_ack) begin
                  credit       <= '0;
                  change_valid <= 1'b0;
                  change_amt   <= '0;
                  state        <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef VEND_STATS_EN
   logic vend_fire;
   logic refund_fire;

   assign refund_fire = (state == CREDIT) && cancel;
   assign vend_fire   = (state == CREDIT) && !cancel && sel_valid && sel_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vend_count   <= '0;
         refund_count <= '0;
      end else begin
         if (vend_fire && (vend_count != '1))     vend_count   <= vend_count + 16'd1;
         if (refund_fire && (refund_count != '1)) refund_count <= refund_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vending_fsm_param.sv
// Scoreboard bench for vending_fsm_param: a credit-level reference model queues
// expected events per cycle; an independent monitor pops and compares them.
module tb_vending_fsm_param;

   // Six products gives a 3-bit sel, so indices 6 and 7 exercise the out-of-range rule.
   localparam int N_PROD = 6;
   localparam int STEP   = 5;
   localparam int CW     = 6;
   localparam int MAXC   = 40;
   localparam int SEL_W  = $clog2(N_PROD);

   logic             clk;
   logic             rst_n;
   logic             coin_valid;
   logic [1:0]       coin_code;
   logic             sel_valid;
   logic [SEL_W-1:0] sel;
   logic             cancel;
   logic             change_ack;
   logic [CW-1:0]    credit;
   logic             coin_reject;
   logic             sel_short;
   logic             dispense;
   logic [SEL_W-1:0] dispense_id;
   logic             change_valid;
   logic [CW-1:0]    change_amt;
`ifdef VEND_STATS_EN
   logic [15:0]      vend_count;
   logic [15:0]      refund_count;
`endif

   vending_fsm_param #(
      .NUM_PRODUCTS (N_PROD),
      .PRICE_STEP   (STEP),
      .CREDIT_W     (CW),
      .MAX_CREDIT   (MAXC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_code    (coin_code),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .change_ack   (change_ack),
      .credit       (credit),
      .coin_reject  (coin_reject),
      .sel_short    (sel_short),
      .dispense     (dispense),
      .dispense_id  (dispense_id),
      .change_valid (change_valid),
      .change_amt   (change_amt)
`ifdef VEND_STATS_EN
      ,
      .vend_count   (vend_count),
      .refund_count (refund_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int check_cnt = 0;

   task automatic check(input string name, input bit ok, input int act, input int exp);
      check_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   // ---------------- scoreboard queues ----------------
   typedef struct {
      int cyc;
      int data;
   } ev_t;

   typedef struct {
      int cyc;
      int credit;
      bit cv;
      int amt;
      int vends;
      int refunds;
   } st_t;

   ev_t rej_q[$];
   ev_t short_q[$];
   ev_t disp_q[$];
   ev_t chg_q[$];
   st_t st_q[$];

   function automatic ev_t mk_ev(input int c, input int d);
      ev_t e;
      e.cyc  = c;
      e.data = d;
      return e;
   endfunction

   // ---------------- reference model (credit-level) ----------------
   int m_credit  = 0;  // credit currently held
   bit m_vend    = 0;  // dispense is being shown this cycle
   bit m_chg     = 0;  // change is being offered this cycle
   int m_amt     = 0;
   int m_vends   = 0;
   int m_refunds = 0;

   function automatic int coin_val(input int code);
      case (code)
         0: return 5;
         1: return 10;
         2: return 20;
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input int t, input bit cv, input int code, input bit sv,
                             input int s, input bit cn, input bit ack);
      int val;
      int price;
      bit coin_ok;
      st_t st;
      val     = coin_val(code);
      price   = (s + 1) * STEP;
      coin_ok = cv && (code != 3) && (m_credit + val <= MAXC);
      if (m_chg) begin
         if (cv) rej_q.push_back(mk_ev(t, 0));
         if (ack) begin
            m_chg    = 0;
            m_amt    = 0;
            m_credit = 0;
         end
      end else if (m_vend) begin
         if (cv) rej_q.push_back(mk_ev(t, 0));
         m_vend = 0;
         if (m_credit != 0) begin
            m_chg = 1;
            m_amt = m_credit;
            chg_q.push_back(mk_ev(t, m_credit));
         end
      end else if (m_credit == 0) begin
         if (sv) short_q.push_back(mk_ev(t, 0));
         if (coin_ok) m_credit = val;
         else if (cv) rej_q.push_back(mk_ev(t, 0));
      end else if (cn) begin
         if (cv) rej_q.push_back(mk_ev(t, 0));
         m_chg = 1;
         m_amt = m_credit;
         chg_q.push_back(mk_ev(t, m_credit));
         if (m_refunds < 65535) m_refunds++;
      end else if (sv) begin
         if (cv) rej_q.push_back(mk_ev(t, 0));
         if (s < N_PROD && m_credit >= price) begin
            m_credit -= price;
            m_vend = 1;
            disp_q.push_back(mk_ev(t, s));
            if (m_vends < 65535) m_vends++;
         end else begin
            short_q.push_back(mk_ev(t, 0));
         end
      end else if (cv) begin
         if (coin_ok) m_credit += val;
         else rej_q.push_back(mk_ev(t, 0));
      end
      st.cyc     = t;
      st.credit  = m_credit;
      st.cv      = m_chg;
      st.amt     = m_amt;
      st.vends   = m_vends;
      st.refunds = m_refunds;
      st_q.push_back(st);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit cv, input int code, input bit sv, input int s,
                        input bit cn, input bit ack);
      coin_valid = cv;
      coin_code  = 2'(code);
      sel_valid  = sv;
      sel        = SEL_W'(s);
      cancel     = cn;
      change_ack = ack;
      model_step(cyc + 1, cv, code, sv, s, cn, ack);
      @(posedge clk);
      #1;
      coin_valid = 1'b0;
      sel_valid  = 1'b0;
      cancel     = 1'b0;
      change_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic coin(input int code);
      drive(1, code, 0, 0, 0, 0);
   endtask

   task automatic pick(input int s);
      drive(0, 0, 1, s, 0, 0);
   endtask

   // Waits (bounded) for change to be offered, holds off for 'delay' cycles, then acks.
   task automatic ack_after(input int delay);
      for (int g = 0; g < 8 && !m_chg; g++) idle(1);
      idle(delay);
      drive(0, 0, 0, 0, 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " credit"}, credit == '0, int'(credit), 0);
      check({tag, " coin_reject"}, coin_reject == 1'b0, int'(coin_reject), 0);
      check({tag, " sel_short"}, sel_short == 1'b0, int'(sel_short), 0);
      check({tag, " dispense"}, dispense == 1'b0, int'(dispense), 0);
      check({tag, " dispense_id"}, dispense_id == '0, int'(dispense_id), 0);
      check({tag, " change_valid"}, change_valid == 1'b0, int'(change_valid), 0);
      check({tag, " change_amt"}, change_amt == '0, int'(change_amt), 0);
`ifdef VEND_STATS_EN
      check({tag, " vend_count"}, vend_count == '0, int'(vend_count), 0);
      check({tag, " refund_count"}, refund_count == '0, int'(refund_count), 0);
`endif
   endtask

   // ---------------- monitor ----------------
   bit  mon_en  = 0;
   bit  cv_prev = 0;
   bit  exp_b;
   bit  rise;
   ev_t e;
   st_t s_exp;

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         exp_b = (rej_q.size() > 0) && (rej_q[0].cyc == cyc);
         if (exp_b) e = rej_q.pop_front();
         check("coin_reject", coin_reject == exp_b, int'(coin_reject), int'(exp_b));

         exp_b = (short_q.size() > 0) && (short_q[0].cyc == cyc);
         if (exp_b) e = short_q.pop_front();
         check("sel_short", sel_short == exp_b, int'(sel_short), int'(exp_b));

         exp_b = (disp_q.size() > 0) && (disp_q[0].cyc == cyc);
         check("dispense", dispense == exp_b, int'(dispense), int'(exp_b));
         if (exp_b) begin
            e = disp_q.pop_front();
            if (dispense) check("dispense_id", int'(dispense_id) == e.data, int'(dispense_id), e.data);
         end

         rise  = change_valid && !cv_prev;
         exp_b = (chg_q.size() > 0) && (chg_q[0].cyc == cyc);
         check("change_valid start", rise == exp_b, int'(rise), int'(exp_b));
         if (exp_b) begin
            e = chg_q.pop_front();
            if (rise) check("change_amt start", int'(change_amt) == e.data, int'(change_amt), e.data);
         end

         if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            s_exp = st_q.pop_front();
            check("credit", int'(credit) == s_exp.credit, int'(credit), s_exp.credit);
            check("change_valid level", change_valid == s_exp.cv, int'(change_valid), int'(s_exp.cv));
            if (s_exp.cv) check("change_amt held", int'(change_amt) == s_exp.amt, int'(change_amt), s_exp.amt);
`ifdef VEND_STATS_EN
            check("vend_count", int'(vend_count) == s_exp.vends, int'(vend_count), s_exp.vends);
            check("refund_count", int'(refund_count) == s_exp.refunds, int'(refund_count), s_exp.refunds);
`endif
         end
      end
      cv_prev = rst_n ? change_valid : 1'b0;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n      = 1'b0;
      coin_valid = 1'b0;
      coin_code  = 2'd0;
      sel_valid  = 1'b0;
      sel        = '0;
      cancel     = 1'b0;
      change_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n  = 1'b1;
      mon_en = 1;

      // 1: 10+10, buy product 2 (15), 5 change
      coin(1); coin(1); pick(2); ack_after(0); idle(2);

      // 2: short on 5 vs 20, then top up with 20 and buy
      coin(0); pick(3); coin(2); pick(3); ack_after(1); idle(1);

      // 3: fill to MAX_CREDIT, overflow coin and invalid coin rejected, then refund
      coin(2); coin(2); coin(1); coin(3);
      drive(0, 0, 0, 0, 1, 0); ack_after(0); idle(1);

      // 4: cancel beats sel; delayed ack keeps change offered
      coin(1); drive(0, 0, 1, 0, 1, 0); ack_after(5); idle(1);
      coin(2); drive(1, 0, 1, 1, 1, 0); ack_after(2);

      // 5: exact price, no change; coin during the dispense cycle rejected
      coin(0); pick(0); coin(0); idle(2);

      // selection edge cases: out-of-range index, sel in IDLE, stray ack/cancel
      pick(4); drive(0, 0, 0, 0, 1, 1);
      coin(2); pick(6); pick(7); pick(5); drive(1, 1, 1, 3, 0, 0); ack_after(0); idle(1);

      // 6: reset abandons a partially paid transaction
      coin(1); coin(0);
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      rej_q.delete(); short_q.delete(); disp_q.delete(); chg_q.delete(); st_q.delete();
      m_credit = 0; m_vend = 0; m_chg = 0; m_amt = 0; m_vends = 0; m_refunds = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1;
      coin(0); pick(0); idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 10) < 3, int'($urandom % 4), ($urandom % 10) < 2,
               int'($urandom % 8), ($urandom % 100) < 6, ($urandom % 10) < 4);
      end
      for (int i = 0; i < 8 && m_chg; i++) drive(0, 0, 0, 0, 0, 1);
      idle(3);

      check("events left unseen", (rej_q.size() + short_q.size() + disp_q.size() + chg_q.size()) == 0,
            rej_q.size() + short_q.size() + disp_q.size() + chg_q.size(), 0);
      mon_en = 0;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
Parametrised, clocked vending controller. Successor to the fixed 4-product, combinational vending block.
- Accumulates credit from multiple coins and accepts a product selection.
- Emits a one-cycle dispense pulse, then returns change over a valid/ack handshake.
- Supports cancel/refund, overflow coin rejection and a configurable product count.
- Sits between the coin-acceptor front end and the dispense/change actuators.

Parameters:
NUM_PRODUCTS, 4, number of selectable products (2..16).
PRICE_STEP, 5, price of product k is (k+1)*PRICE_STEP.
CREDIT_W, 6, width of the credit, price and change datapath.
MAX_CREDIT, 40, highest credit held; a coin that would exceed it is rejected.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin_valid  in  1  one-cycle strobe: coin present
coin_code  in  2  0=5, 1=10, 2=20, 3=invalid
sel_valid  in  1  one-cycle strobe: product selected
sel  in  $clog2(NUM_PRODUCTS)  product index
cancel  in  1  one-cycle strobe: refund request
change_ack  in  1  change actuator has taken change_amt
credit  out  CREDIT_W  current accumulated credit
coin_reject  out  1  one-cycle pulse: coin refused
sel_short  out  1  one-cycle pulse: credit below price, or sel out of range
dispense  out  1  one-cycle pulse: vend product
dispense_id  out  $clog2(NUM_PRODUCTS)  product being vended, valid with dispense
change_valid  out  1  change_amt valid; held until change_ack
change_amt  out  CREDIT_W  change to return

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0.
- All outputs are registered, and every response appears the cycle after its input strobe.
- States:
  - IDLE: credit=0. An accepted coin moves to CREDIT.
  - CREDIT: accumulate coins. sel_valid moves to VEND or pulses sel_short. cancel moves to CHANGE with change_amt=credit.
  - VEND: dispense=1 for one cycle and credit -= price. Go to CHANGE if the remainder is nonzero, else IDLE.
  - CHANGE: change_valid=1 and change_amt=remainder, both held until change_ack. In the ack cycle: credit cleared, go IDLE, change_valid drops next cycle.
- Coin acceptance:
  - code 3 is always rejected.
  - A coin is rejected if credit+value > MAX_CREDIT.
  - A coin is rejected in VEND or CHANGE.
  - A rejected coin leaves credit unchanged and pulses coin_reject for one cycle.
- Selection rules:
  - sel >= NUM_PRODUCTS pulses sel_short.
  - credit < price pulses sel_short and leaves the state in CREDIT.
  - sel_valid in IDLE pulses sel_short.
  - sel_valid or cancel in VEND/CHANGE is ignored.
- Simultaneous strobes in CREDIT: cancel > sel_valid > coin_valid. A losing coin is rejected (coin_reject); a losing sel is dropped silently.
- Arithmetic: all sums in CREDIT_W+1 bits, compared before truncation. Prices are computed at elaboration. MAX_CREDIT must fit in CREDIT_W (elaboration assertion).
- Reset mid-operation: any pending dispense or change is abandoned and credit is lost.
- change_ack outside CHANGE is ignored.

Optional Feature:
VEND_STATS_EN:
- When defined, adds outputs vend_count[15:0] (saturating count of dispense pulses) and refund_count[15:0] (saturating count of cancels accepted). Both reset to 0.
- When undefined, neither port nor counter exists and the behaviour above is unchanged.

Decomposition:
- Package vending_pkg holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE)
  - coin code localparams and a coin_value function (code -> value, 0 for invalid).
- Sub-module vend_price_lut (combinational) maps sel to price and an in-range flag from NUM_PRODUCTS and PRICE_STEP. It is instantiated once.

Test Plan:
1. Coins 10,10 then sel=2 (price 15) -> credit 20; dispense pulse with dispense_id=2; change_valid with change_amt=5 until ack; then IDLE, credit 0.
2. Coin 5 then sel=3 (price 20) -> sel_short pulse, credit stays 5. Then coin 20 and sel=3 -> dispense, change_amt=5.
3. Coins 20,20 then coin 10 (MAX_CREDIT=40) -> third coin gives coin_reject, credit=40. Coin code 3 -> coin_reject.
4. Coin 10, then cancel and sel_valid in the same cycle -> no dispense, change_amt=10; change_ack delayed 5 cycles keeps change_valid high throughout.
5. Coin 5 then sel=0 (exact price) -> dispense, change_valid never asserts, back to IDLE. Coin strobed in the VEND cycle -> coin_reject.
6. Coins 10,5 then rst_n low mid-CREDIT -> all outputs 0 immediately, state IDLE. With VEND_STATS_EN, vend_count increments per dispense.
